// File: rtl/ballot_tally_engine.sv
// Ballot tally engine: captures one vote per button release, enforces a post-vote lockout,
// keeps saturating per-candidate counts and, after close, scans for the leader and a tie.
module ballot_tally_engine #(
  parameter  int NUM_CAND = 4,
  parameter  int CNT_W    = 16,
  parameter  int HOLD_CYC = 16,
  localparam int LEAD_W   = $clog2(NUM_CAND),
  localparam int TOT_W    = CNT_W + $clog2(NUM_CAND + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CAND-1:0]       i_vote,
  input  logic                      i_open,
  input  logic                      i_close,
  output logic [NUM_CAND*CNT_W-1:0] o_counts,
  output logic [TOT_W-1:0]          o_total,
  output logic                      o_accept,
  output logic                      o_reject,
  output logic                      o_sat,
  output logic [1:0]                o_state,
  output logic [LEAD_W-1:0]         o_leader,
  output logic                      o_tie,
  output logic                      o_result_valid
);

  localparam int TMR_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VOTE   = 2'd1,
    S_HOLD   = 2'd2,
    S_CLOSED = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [NUM_CAND-1:0] prev_vote;
  logic [NUM_CAND-1:0] rel_edge;
  logic                one_edge, multi_edge;
  logic [LEAD_W-1:0]   edge_idx;
  logic                tgt_full;
  logic [CNT_W-1:0]    cnt [NUM_CAND];

  logic                do_accept, do_reject, clear_session, enter_closed;
  logic [TMR_W-1:0]    hold_tmr;
  logic                hold_done;

  logic                scan_busy, scan_step, scan_last;
  logic [LEAD_W-1:0]   scan_idx;
  logic [CNT_W-1:0]    scan_val;
  logic [CNT_W-1:0]    run_max, step_max;
  logic [LEAD_W-1:0]   run_idx, step_idx;
  logic                run_tie, step_tie;

  // Release-edge decode; a single set bit is a valid vote, more is a multi-press.
  always_comb begin
    rel_edge   = prev_vote & ~i_vote;
    one_edge   = (rel_edge != '0) && ((rel_edge & (rel_edge - NUM_CAND'(1))) == '0);
    multi_edge = (rel_edge != '0) && !one_edge;
    edge_idx   = '0;
    for (int k = 0; k < NUM_CAND; k++) begin
      if (rel_edge[k]) edge_idx = LEAD_W'(k);
    end
    tgt_full = (cnt[edge_idx] == CNT_MAX);
  end

  assign hold_done = (hold_tmr == TMR_W'(HOLD_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_n       = state;
    do_accept     = 1'b0;
    do_reject     = 1'b0;
    clear_session = 1'b0;
    enter_closed  = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_open) begin
          state_n       = S_VOTE;
          clear_session = 1'b1;
        end
      end
      S_VOTE: begin
        if (i_close) begin
          state_n      = S_CLOSED;
          enter_closed = 1'b1;
        end else if (one_edge) begin
          state_n = S_HOLD;
          if (tgt_full) do_reject = 1'b1;
          else          do_accept = 1'b1;
        end else if (multi_edge) begin
          state_n   = S_HOLD;
          do_reject = 1'b1;
        end
      end
      S_HOLD: begin
        if (i_close) begin
          state_n      = S_CLOSED;
          enter_closed = 1'b1;
        end else if (hold_done) begin
          state_n = S_VOTE;
        end
      end
      S_CLOSED: begin
        if (!i_close) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // One candidate per cycle; strict '>' keeps the lowest index among equal maxima.
  always_comb begin
    scan_step = (state == S_CLOSED) && i_close && scan_busy;
    scan_last = (scan_idx == LEAD_W'(NUM_CAND - 1));
    scan_val  = cnt[scan_idx];
    step_max  = run_max;
    step_idx  = run_idx;
    step_tie  = run_tie;
    if (scan_idx == '0) begin
      step_max = scan_val;
      step_idx = '0;
      step_tie = 1'b0;
    end else if (scan_val > run_max) begin
      step_max = scan_val;
      step_idx = scan_idx;
      step_tie = 1'b0;
    end else if (scan_val == run_max) begin
      step_tie = 1'b1;
    end
  end

  // NOTE: the counter array is reset explicitly because a reset mid-session must discard all votes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_vote      <= '0;
      o_accept       <= 1'b0;
      o_reject       <= 1'b0;
      o_total        <= '0;
      o_sat          <= 1'b0;
      hold_tmr       <= '0;
      scan_busy      <= 1'b0;
      scan_idx       <= '0;
      run_max        <= '0;
      run_idx        <= '0;
      run_tie        <= 1'b0;
      o_leader       <= '0;
      o_tie          <= 1'b0;
      o_result_valid <= 1'b0;
      for (int k = 0; k < NUM_CAND; k++) cnt[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      prev_vote <= i_vote;
      o_accept  <= do_accept;
      o_reject  <= do_reject;
      hold_tmr  <= (state == S_HOLD) ? hold_tmr + TMR_W'(1) : '0;

      if (clear_session) begin
        for (int k = 0; k < NUM_CAND; k++) cnt[k] <= '0;
        o_total        <= '0;
        o_sat          <= 1'b0;
        o_result_valid <= 1'b0;
      end

      if (do_accept) begin
        cnt[edge_idx] <= cnt[edge_idx] + CNT_W'(1);
        o_total       <= o_total + TOT_W'(1);
        if ((cnt[edge_idx] + CNT_W'(1)) == CNT_MAX) o_sat <= 1'b1;
      end

      if (enter_closed) begin
        scan_idx  <= '0;
        scan_busy <= 1'b1;
      end else if (scan_step) begin
        run_max <= step_max;
        run_idx <= step_idx;
        run_tie <= step_tie;
        if (scan_last) begin
          scan_busy      <= 1'b0;
          o_leader       <= step_idx;
          o_tie          <= step_tie;
          o_result_valid <= 1'b1;
        end else begin
          scan_idx <= scan_idx + LEAD_W'(1);
        end
      end else if ((state == S_CLOSED) && !i_close) begin
        scan_busy <= 1'b0;
      end
    end
  end

  always_comb begin
    o_counts = '0;
    for (int k = 0; k < NUM_CAND; k++) o_counts[k*CNT_W +: CNT_W] = cnt[k];
  end

  assign o_state = state;

  a_pulse_excl: assert property (@(posedge clk) disable iff (rst) !(o_accept && o_reject));

endmodule
